// File: rtl/rpsc_pkg.sv
// rtl/rpsc_pkg.sv - shared defaults and per-channel state type for the RPSC fault latch bank
package rpsc_pkg;

    localparam int RPSC_SYNC_STAGES = 2;
    localparam int RPSC_DEBOUNCE    = 4;
    localparam int RPSC_DB_CNT_W    = 8;

    typedef struct packed {
        logic [RPSC_DB_CNT_W-1:0] cnt;
        logic                     out;
        logic                     latch;
    } chan_state_t;

endpackage

// File: rtl/rpsc_ff_chan.sv
// rtl/rpsc_ff_chan.sv - one channel: synchroniser, debounce filter, live state and alarm latch
module rpsc_ff_chan
    import rpsc_pkg::*;
#(
    parameter int SYNC_STAGES = RPSC_SYNC_STAGES,
    parameter int DEBOUNCE    = RPSC_DEBOUNCE
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic in_i,
    input  logic mask_i,
    input  logic ack_i,
    output logic out_o,
    output logic latch_o,
    output logic set_o
);

    localparam logic [RPSC_DB_CNT_W-1:0] CNT_LAST = RPSC_DB_CNT_W'(DEBOUNCE - 1);
    localparam logic [RPSC_DB_CNT_W-1:0] CNT_ONE  = RPSC_DB_CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    chan_state_t            st_q, st_d;
    logic                   s;
    logic                   set;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
    assign s      = sync_q[SYNC_STAGES-1];
    assign set    = st_q.out & ~mask_i & ~st_q.latch;

    always_comb begin
        st_d = st_q;
        if (s == st_q.out) begin
            st_d.cnt = '0;
        end else if (st_q.cnt == CNT_LAST) begin
            st_d.out = s;
            st_d.cnt = '0;
        end else begin
            st_d.cnt = st_q.cnt + CNT_ONE;
        end
        // Set has priority over ack; ack only releases channels whose input has gone quiet.
        if (set) begin
            st_d.latch = 1'b1;
        end else if (ack_i && !st_q.out) begin
            st_d.latch = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync_q <= '0;
            st_q   <= '0;
        end else begin
            sync_q <= sync_d;
            st_q   <= st_d;
        end
    end

    assign out_o   = st_q.out;
    assign latch_o = st_q.latch;
    assign set_o   = set;

endmodule

// File: rtl/rpsc_fault_latch_bank.sv
// rtl/rpsc_fault_latch_bank.sv - N-channel fault/permit latch card with first-fault capture and event counter
module rpsc_fault_latch_bank
    import rpsc_pkg::*;
#(
    parameter  int N_CH        = 8,
    parameter  int SYNC_STAGES = RPSC_SYNC_STAGES,
    parameter  int DEBOUNCE    = RPSC_DEBOUNCE,
    parameter  int CNT_W       = 8,
    localparam int IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             LA_Test,
    input  logic [N_CH-1:0]  in,
    input  logic [N_CH-1:0]  mask,
    input  logic             ack,
    output logic [N_CH-1:0]  out,
    output logic [N_CH-1:0]  LA,
    output logic             any_alarm,
    output logic             first_fault_valid,
    output logic [IDX_W-1:0] first_fault_idx,
    output logic [CNT_W-1:0] event_count
);

    logic [N_CH-1:0]  latch;
    logic [N_CH-1:0]  set;
    logic [N_CH-1:0]  retained;
    logic             any_set;
    logic [IDX_W-1:0] set_idx;

    logic             ff_valid_q, ff_valid_d;
    logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        rpsc_ff_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE)
        ) u_chan (
            .clk_i   (clk),
            .resetn_i(reset),
            .in_i    (in[i]),
            .mask_i  (mask[i]),
            .ack_i   (ack),
            .out_o   (out[i]),
            .latch_o (latch[i]),
            .set_o   (set[i])
        );
    end

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CH-1:0] v);
        lowest_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    assign any_set  = |set;
    assign set_idx  = lowest_idx(set);
    // Latches that survive this edge ignoring new sets; empty means ack releases the capture.
    assign retained = ack ? (latch & out) : latch;

    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        if (ack && (retained == '0)) begin
            ff_valid_d = any_set;
            ff_idx_d   = any_set ? set_idx : '0;
        end else if (!ff_valid_q && any_set) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = set_idx;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (any_set && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            cnt_q      <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign LA                = latch | {N_CH{LA_Test}};
    assign any_alarm         = |latch;
    assign first_fault_valid = ff_valid_q;
    assign first_fault_idx   = ff_idx_q;
    assign event_count       = cnt_q;

endmodule

// File: tb/tb_rpsc_fault_latch_bank.sv
// tb/tb_rpsc_fault_latch_bank.sv - directed self-checking bench for rpsc_fault_latch_bank
module tb_rpsc_fault_latch_bank;

    logic       clk;
    logic       reset;
    logic       LA_Test;
    logic [7:0] in;
    logic [7:0] mask;
    logic       ack;
    logic [7:0] out;
    logic [7:0] LA;
    logic       any_alarm;
    logic       first_fault_valid;
    logic [2:0] first_fault_idx;
    logic [7:0] event_count;

    int checks;
    int failures;

    rpsc_fault_latch_bank #(
        .N_CH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .LA_Test          (LA_Test),
        .in               (in),
        .mask             (mask),
        .ack              (ack),
        .out              (out),
        .LA               (LA),
        .any_alarm        (any_alarm),
        .first_fault_valid(first_fault_valid),
        .first_fault_idx  (first_fault_idx),
        .event_count      (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        LA_Test  = 1'b0;
        in       = 8'hFF;
        mask     = 8'h00;
        ack      = 1'b0;

        // 1: reset state with all inputs high, then full latency after release
        step(3);
        check_eq("rst_out", 32'(out), 32'h00);
        check_eq("rst_la", 32'(LA), 32'h00);
        check_eq("rst_cnt", 32'(event_count), 32'h00);
        check_eq("rst_ffv", 32'(first_fault_valid), 32'h0);
        reset = 1'b1;
        step(5);
        check_eq("t1_out_c5", 32'(out), 32'h00);
        step(1);
        check_eq("t1_out_c6", 32'(out), 32'hFF);
        check_eq("t1_la_c6", 32'(LA), 32'h00);
        step(1);
        check_eq("t1_la_c7", 32'(LA), 32'hFF);
        check_eq("t1_ffidx", 32'(first_fault_idx), 32'h0);
        check_eq("t1_ffv", 32'(first_fault_valid), 32'h1);
        check_eq("t1_cnt", 32'(event_count), 32'h1);

        // 2: short glitch rejected, 4-cycle pulse accepted
        do_reset();
        in = 8'h08;
        step(3);
        in = 8'h00;
        step(10);
        check_eq("t2_glitch_out", 32'(out), 32'h00);
        check_eq("t2_glitch_la", 32'(LA), 32'h00);
        in = 8'h08;
        step(4);
        in = 8'h00;
        step(1);
        check_eq("t2_out_c5", 32'(out), 32'h00);
        step(1);
        check_eq("t2_out_c6", 32'(out), 32'h08);
        step(1);
        check_eq("t2_la_c7", 32'(LA), 32'h08);
        check_eq("t2_ffidx", 32'(first_fault_idx), 32'h3);
        check_eq("t2_cnt", 32'(event_count), 32'h1);

        // 3: simultaneous sets -> lowest index; later set does not move index
        do_reset();
        in = 8'h24;
        step(7);
        check_eq("t3_la", 32'(LA), 32'h24);
        check_eq("t3_ffidx", 32'(first_fault_idx), 32'h2);
        check_eq("t3_cnt", 32'(event_count), 32'h1);
        in = 8'h64;
        step(7);
        check_eq("t3_la2", 32'(LA), 32'h64);
        check_eq("t3_ffidx2", 32'(first_fault_idx), 32'h2);
        check_eq("t3_cnt2", 32'(event_count), 32'h2);

        // 4: ack clears only quiet channels; full clear drops first fault
        in = 8'h44;
        step(6);
        check_eq("t4_out", 32'(out), 32'h44);
        pulse_ack();
        check_eq("t4_la_partial", 32'(LA), 32'h44);
        check_eq("t4_ffv_hold", 32'(first_fault_valid), 32'h1);
        in = 8'h00;
        step(6);
        pulse_ack();
        check_eq("t4_la_clear", 32'(LA), 32'h00);
        check_eq("t4_ffv_clear", 32'(first_fault_valid), 32'h0);
        check_eq("t4_ffidx_clear", 32'(first_fault_idx), 32'h0);
        check_eq("t4_any", 32'(any_alarm), 32'h0);

        // 5: mask blocks setting only; lamp test drives LA alone
        do_reset();
        mask = 8'h10;
        in   = 8'h10;
        step(6);
        check_eq("t5_out", 32'(out), 32'h10);
        step(4);
        in = 8'h00;
        check_eq("t5_la_masked", 32'(LA), 32'h00);
        check_eq("t5_cnt", 32'(event_count), 32'h0);
        LA_Test = 1'b1;
        #1;
        check_eq("t5_lamp_la", 32'(LA), 32'hFF);
        check_eq("t5_lamp_any", 32'(any_alarm), 32'h0);
        LA_Test = 1'b0;
        mask = 8'h00;
        step(1);
        check_eq("t5_unmask_la", 32'(LA), 32'h10);
        mask = 8'h10;
        step(1);
        check_eq("t5_mask_keeps", 32'(LA), 32'h10);
        check_eq("t5_ffidx", 32'(first_fault_idx), 32'h4);

        // 6: saturation of the event counter, then reset in mid-debounce
        do_reset();
        mask = 8'h00;
        for (int k = 1; k <= 300; k++) begin
            in = 8'h01;
            step(7);
            in = 8'h00;
            step(6);
            pulse_ack();
            if (k == 254) check_eq("t6_cnt_254", 32'(event_count), 32'd254);
            if (k == 255) check_eq("t6_cnt_255", 32'(event_count), 32'd255);
        end
        check_eq("t6_cnt_sat", 32'(event_count), 32'd255);
        in = 8'h01;
        step(4);
        reset = 1'b0;
        step(1);
        check_eq("t6_rst_out", 32'(out), 32'h00);
        check_eq("t6_rst_cnt", 32'(event_count), 32'h00);
        reset = 1'b1;
        step(5);
        check_eq("t6_relatch_c5", 32'(out), 32'h00);
        step(1);
        check_eq("t6_relatch_c6", 32'(out), 32'h01);
        step(1);
        check_eq("t6_relatch_la", 32'(LA), 32'h01);
        check_eq("t6_relatch_cnt", 32'(event_count), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
